// File: rtl/alu_issue_pkg.sv
// Shared opcode map and issue-FSM encoding for the ALU issue stage and the ALU itself.
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_RED    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    // Upper opcode bits select the memory-address (10xx) and control (11xx) classes.
    localparam logic [1:0] OP_MEM_HI  = 2'b10;
    localparam logic [1:0] OP_CTRL_HI = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return op[3:2] == OP_MEM_HI;
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_issue_imm_sel.sv
// Operand-B selection: register operand, zero-extended shift amount, or sign-extended offset.
module imm_sel
    import alu_issue_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [15:0] rt_data,
    input  logic [3:0]  imm,
    output logic [15:0] alu_b
);

    always_comb begin
        alu_b = rt_data;
        if (is_mem_op(opcode)) begin
            alu_b = {{12{imm[3]}}, imm};
        end else if (is_shift_op(opcode)) begin
            alu_b = {12'h000, imm};
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Three-state issue stage: latch operands for an external ALU, capture its result,
// and hold a writeback until the consumer accepts it.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    input  logic [15:0] rs_data,
    input  logic [15:0] rt_data,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    input  logic        alu_ovfl,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        wb_mem,
    output logic [2:0]  flags,
    output logic        unsup
);

    state_e      state_q, state_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        wb_mem_q, wb_mem_d;
    logic [2:0]  flags_q, flags_d;
    logic        unsup_q, unsup_d;
    logic [15:0] alu_b_sel;

    // The rs register index is resolved upstream; only its data reaches this block.
    logic unused_rs_idx;
    assign unused_rs_idx = ^instr[7:4];

    imm_sel u_imm_sel (
        .opcode  (instr[15:12]),
        .rt_data (rt_data),
        .imm     (instr[3:0]),
        .alu_b   (alu_b_sel)
    );

    // NOTE: every output of this block is given a default first, so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rd_d        = rd_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_mem_d    = wb_mem_q;
        flags_d     = flags_q;
        unsup_d     = 1'b0;
        instr_ready = (state_q == ST_IDLE);
        wb_valid    = (state_q == ST_WB);

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (instr[15:14] == OP_CTRL_HI) begin
                        unsup_d = 1'b1;
                    end else begin
                        alu_op_d = instr[15:12];
                        alu_a_d  = rs_data;
                        alu_b_d  = alu_b_sel;
                        rd_d     = instr[11:8];
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                wb_data_d = alu_out;
                wb_rd_d   = rd_q;
                wb_mem_d  = is_mem_op(alu_op_q);
                if ((alu_op_q == OP_ADD) || (alu_op_q == OP_SUB)) begin
                    flags_d = {alu_out[15], alu_out == 16'h0000, alu_ovfl};
                end else if ((alu_op_q == OP_XOR) || is_shift_op(alu_op_q)) begin
                    flags_d[1] = (alu_out == 16'h0000);
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            alu_op_q  <= 4'h0;
            alu_a_q   <= 16'h0000;
            alu_b_q   <= 16'h0000;
            rd_q      <= 4'h0;
            wb_rd_q   <= 4'h0;
            wb_data_q <= 16'h0000;
            wb_mem_q  <= 1'b0;
            flags_q   <= 3'b000;
            unsup_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_mem_q  <= wb_mem_d;
            flags_q   <= flags_d;
            unsup_q   <= unsup_d;
        end
    end

    assign alu_op  = alu_op_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign wb_mem  = wb_mem_q;
    assign flags   = flags_q;
    assign unsup   = unsup_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural saturating ALU attached.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk, rst, instr_valid, instr_ready, wb_ready, alu_ovfl;
    logic [15:0] instr, rs_data, rt_data, alu_a, alu_b, alu_out, wb_data;
    logic [3:0]  alu_op, wb_rd;
    logic        wb_valid, wb_mem, unsup;
    logic [2:0]  flags;
    int          checks, errors;

    alu_issue dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_ovfl(alu_ovfl),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_mem(wb_mem), .flags(flags), .unsup(unsup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: saturating ADD/SUB, shifts, and base + (offset << 1) for 10xx.
    logic [15:0] sum, dif;
    logic        sum_ov, dif_ov;
    always_comb begin
        sum    = alu_a + alu_b;
        dif    = alu_a - alu_b;
        sum_ov = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
        dif_ov = (alu_a[15] != alu_b[15]) && (dif[15] != alu_a[15]);
        alu_ovfl = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_out  = sum_ov ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : sum;
                alu_ovfl = sum_ov;
            end
            OP_SUB: begin
                alu_out  = dif_ov ? (alu_a[15] ? 16'h8000 : 16'h7FFF) : dif;
                alu_ovfl = dif_ov;
            end
            OP_XOR:  alu_out = alu_a ^ alu_b;
            OP_SLL:  alu_out = alu_a << alu_b[3:0];
            OP_SRA:  alu_out = $unsigned($signed(alu_a) >>> alu_b[3:0]);
            OP_ROR:  alu_out = (alu_a >> alu_b[3:0]) | (alu_a << (5'd16 - {1'b0, alu_b[3:0]}));
            OP_RED, OP_PADDSB: alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a + {alu_b[14:0], 1'b0};
        endcase
    end

    // Offer an instruction at the current negedge, step past the accept edge into EXEC.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] imm,
                         input logic [15:0] a, input logic [15:0] b);
        instr_valid = 1'b1;
        instr       = {op, rd, 4'h2, imm};
        rs_data     = a;
        rt_data     = b;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        checks++; if (unsup !== 1'b0) begin errors++; $display("FAIL reset_unsup got %b want 0", unsup); end
        checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", flags); end
        checks++; if ({alu_op, alu_a, alu_b} !== 36'h0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_op, alu_a, alu_b}); end
        checks++; if ({wb_rd, wb_data, wb_mem} !== 21'h0) begin errors++; $display("FAIL reset_wb got %h want 0", {wb_rd, wb_data, wb_mem}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_sat;
        issue(OP_ADD, 4'h3, 4'h0, 16'h7FFF, 16'h0001);
        checks++; if ({alu_op, alu_a, alu_b} !== {4'h0, 16'h7FFF, 16'h0001}) begin errors++; $display("FAIL add_issue got %h want 07fff0001", {alu_op, alu_a, alu_b}); end
        checks++; if ({instr_ready, wb_valid} !== 2'b00) begin errors++; $display("FAIL add_exec_hs got %b want 00", {instr_ready, wb_valid}); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid got %b want 1", wb_valid); end
        checks++; if ({wb_rd, wb_data, wb_mem} !== {4'h3, 16'h7FFF, 1'b0}) begin errors++; $display("FAIL add_wb got %h/%h/%b want 3/7fff/0", wb_rd, wb_data, wb_mem); end
        checks++; if (flags !== 3'b001) begin errors++; $display("FAIL add_flags got %b want 001", flags); end
        @(negedge clk);
        checks++; if ({instr_ready, wb_valid} !== 2'b10) begin errors++; $display("FAIL add_idle got %b want 10", {instr_ready, wb_valid}); end
    endtask

    task automatic test_sll_mem;
        issue(OP_SLL, 4'h4, 4'hF, 16'h0001, 16'hAAAA);
        checks++; if (alu_b !== 16'h000F) begin errors++; $display("FAIL sll_alu_b got %h want 000f", alu_b); end
        @(negedge clk);
        checks++; if ({wb_data, wb_mem} !== {16'h8000, 1'b0}) begin errors++; $display("FAIL sll_wb got %h/%b want 8000/0", wb_data, wb_mem); end
        checks++; if (flags !== 3'b001) begin errors++; $display("FAIL sll_flags got %b want 001", flags); end
        @(negedge clk);
        issue(4'b1000, 4'h5, 4'hF, 16'h0100, 16'h1234);
        checks++; if ({alu_op, alu_b} !== {4'b1000, 16'hFFFF}) begin errors++; $display("FAIL mem_issue got %h want 8ffff", {alu_op, alu_b}); end
        @(negedge clk);
        checks++; if ({wb_rd, wb_data, wb_mem} !== {4'h5, 16'h00FE, 1'b1}) begin errors++; $display("FAIL mem_wb got %h/%h/%b want 5/00fe/1", wb_rd, wb_data, wb_mem); end
        checks++; if (flags !== 3'b001) begin errors++; $display("FAIL mem_flags got %b want 001", flags); end
        @(negedge clk);
        issue(OP_SRA, 4'h6, 4'hC, 16'h8000, 16'h0000);
        checks++; if (alu_b !== 16'h000C) begin errors++; $display("FAIL sra_alu_b got %h want 000c", alu_b); end
        @(negedge clk);
        checks++; if ({wb_data, flags} !== {16'hFFF8, 3'b001}) begin errors++; $display("FAIL sra_wb got %h/%b want fff8/001", wb_data, flags); end
        @(negedge clk);
    endtask

    task automatic test_sub;
        issue(OP_SUB, 4'h7, 4'h0, 16'h1234, 16'h1234);
        @(negedge clk);
        checks++; if ({wb_data, flags} !== {16'h0000, 3'b010}) begin errors++; $display("FAIL sub_wb got %h/%b want 0000/010", wb_data, flags); end
        @(negedge clk);
    endtask

    task automatic test_unsup;
        instr_valid = 1'b1;
        instr       = 16'hC9AB;
        rs_data     = 16'h5555;
        rt_data     = 16'h6666;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({unsup, instr_ready, wb_valid} !== 3'b110) begin errors++; $display("FAIL unsup_pulse got %b want 110", {unsup, instr_ready, wb_valid}); end
        checks++; if ({alu_op, alu_a} !== {4'h1, 16'h1234}) begin errors++; $display("FAIL unsup_no_issue got %h want 11234", {alu_op, alu_a}); end
        @(negedge clk);
        checks++; if ({unsup, wb_valid} !== 2'b00) begin errors++; $display("FAIL unsup_end got %b want 00", {unsup, wb_valid}); end
        checks++; if (flags !== 3'b010) begin errors++; $display("FAIL unsup_flags got %b want 010", flags); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL unsup_no_wb got %b want 0", wb_valid); end
    endtask

    task automatic test_xor;
        issue(OP_XOR, 4'h8, 4'h0, 16'h00F0, 16'h000F);
        @(negedge clk);
        checks++; if ({wb_data, flags} !== {16'h00FF, 3'b000}) begin errors++; $display("FAIL xor_wb got %h/%b want 00ff/000", wb_data, flags); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        wb_ready = 1'b0;
        issue(OP_ADD, 4'h5, 4'h0, 16'h0002, 16'h0003);
        instr_valid = 1'b1;
        instr       = {OP_SUB, 4'h6, 4'h2, 4'h0};
        rs_data     = 16'h0010;
        rt_data     = 16'h0004;
        @(negedge clk);
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'h5, 16'h0005}) begin errors++; $display("FAIL b2b_wb got %h want 150005", {wb_valid, wb_rd, wb_data}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({instr_ready, wb_valid, wb_data} !== {2'b01, 16'h0005}) begin errors++; $display("FAIL b2b_stall%0d got %h want 10005", i, {instr_ready, wb_valid, wb_data}); end
        end
        wb_ready = 1'b1;
        @(negedge clk);
        checks++; if ({instr_ready, wb_valid} !== 2'b10) begin errors++; $display("FAIL b2b_release got %b want 10", {instr_ready, wb_valid}); end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++; if ({instr_ready, alu_op, alu_a, alu_b} !== {1'b0, 4'h1, 16'h0010, 16'h0004}) begin errors++; $display("FAIL b2b_second_issue got %h want 0100100004", {instr_ready, alu_op, alu_a, alu_b}); end
        @(negedge clk);
        checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'h6, 16'h000C}) begin errors++; $display("FAIL b2b_second_wb got %h want 16000c", {wb_valid, wb_rd, wb_data}); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b want 0", wb_valid); end
    endtask

    task automatic test_flag_retain;
        issue(OP_ADD, 4'h1, 4'h0, 16'h8000, 16'h0001);
        @(negedge clk);
        checks++; if ({wb_data, flags} !== {16'h8001, 3'b100}) begin errors++; $display("FAIL neg_wb got %h/%b want 8001/100", wb_data, flags); end
        @(negedge clk);
        issue(OP_XOR, 4'h2, 4'h0, 16'h00F0, 16'h000F);
        @(negedge clk);
        checks++; if (flags !== 3'b100) begin errors++; $display("FAIL retain_flags got %b want 100", flags); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec;
        issue(OP_ADD, 4'h9, 4'h0, 16'h7FFF, 16'h0001);
        rst = 1'b1;
        #1;
        checks++; if ({instr_ready, wb_valid, unsup, flags} !== 6'b100000) begin errors++; $display("FAIL rst_mid_ctl got %b want 100000", {instr_ready, wb_valid, unsup, flags}); end
        checks++; if ({alu_op, alu_a, alu_b, wb_rd, wb_data, wb_mem} !== 57'h0) begin errors++; $display("FAIL rst_mid_data got %h want 0", {alu_op, alu_a, alu_b, wb_rd, wb_data, wb_mem}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({wb_valid, flags, wb_data} !== 20'h0) begin errors++; $display("FAIL rst_mid_after%0d got %h want 0", i, {wb_valid, flags, wb_data}); end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        rs_data     = 16'h0000;
        rt_data     = 16'h0000;
        wb_ready    = 1'b1;
        test_reset;
        test_add_sat;
        test_sll_mem;
        test_sub;
        test_unsup;
        test_xor;
        test_back_to_back;
        test_flag_retain;
        test_reset_mid_exec;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
